// File: rtl/gray_pkg.sv
// Shared constants and helpers for the Gray stream decoder.
// Direction codes are only produced when GRAY_DIR_DETECT_EN is defined.
package gray_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 16;
  localparam int MAX_W     = 32;

  localparam logic [1:0] DIR_NONE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

  // Each binary bit is the XOR of its Gray bit and every Gray bit above it.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b = g;
    for (int i = 1; i < MAX_W; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

  function automatic int unsigned popcount(input logic [MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_W; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/gray2bin_comb.sv
// Pure combinational Gray-to-binary decoder, WIDTH bits wide.
module gray2bin_comb #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  // Reduction per bit keeps the logic flat instead of a ripple chain.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign bin_o[gi] = ^gray_i[WIDTH-1:gi];
  end

endmodule

// File: rtl/gray_stream_decoder.sv
// Streaming Gray-to-binary decoder with adjacency checking and a 2-entry output FIFO.
// Optional macro GRAY_DIR_DETECT_EN adds per-word up/down direction detection.
module gray_stream_decoder
  import gray_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_gray,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_binary,
  output logic             out_step_err,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       out_dir
);

  logic [WIDTH-1:0] dec_bin;
  logic             accept;
  logic             pop;
  logic             step_err_d;
  logic [1:0]       dir_d;
  logic [1:0]       count_q, count_d;
  logic             rd_ptr_q, wr_ptr_q;
  logic             first_q;
  logic [WIDTH-1:0] prev_gray_q;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [WIDTH-1:0] bin_q [2];
  logic             err_q [2];
  logic [1:0]       dir_q [2];

  gray2bin_comb #(.WIDTH(WIDTH)) u_dec (
    .gray_i (in_gray),
    .bin_o  (dec_bin)
  );

  // Full buffer can still take a word when the head leaves in the same cycle.
  assign in_ready  = (count_q != 2'd2) || out_ready;
  assign out_valid = (count_q != 2'd0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_binary   = bin_q[rd_ptr_q];
  assign out_step_err = err_q[rd_ptr_q];
  assign out_dir      = dir_q[rd_ptr_q];
  assign err_count    = err_count_q;

  assign step_err_d = !first_q &&
                      (popcount(MAX_W'(in_gray ^ prev_gray_q)) != 32'd1);

`ifdef GRAY_DIR_DETECT_EN
  logic [WIDTH-1:0] prev_bin_q;
  logic [WIDTH-1:0] bin_diff;

  assign bin_diff = dec_bin - prev_bin_q;

  always_comb begin
    dir_d = DIR_NONE;
    if (!first_q) begin
      if (bin_diff == WIDTH'(1)) begin
        dir_d = DIR_UP;
      end else if (bin_diff == {WIDTH{1'b1}}) begin
        dir_d = DIR_DOWN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_bin_q <= '0;
    end else if (accept) begin
      prev_bin_q <= dec_bin;
    end
  end
`else
  assign dir_d = DIR_NONE;
`endif

  always_comb begin
    count_d = count_q;
    case ({accept, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    err_count_d = err_count_q;
    if (accept && step_err_d && (err_count_q != {CNT_W{1'b1}})) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= 2'd0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      first_q     <= 1'b1;
      prev_gray_q <= '0;
      err_count_q <= '0;
      for (int i = 0; i < 2; i++) begin
        bin_q[i] <= '0;
        err_q[i] <= 1'b0;
        dir_q[i] <= DIR_NONE;
      end
    end else begin
      count_q     <= count_d;
      err_count_q <= err_count_d;
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      if (accept) begin
        bin_q[wr_ptr_q] <= dec_bin;
        err_q[wr_ptr_q] <= step_err_d;
        dir_q[wr_ptr_q] <= dir_d;
        wr_ptr_q        <= ~wr_ptr_q;
        first_q         <= 1'b0;
        prev_gray_q     <= in_gray;
      end
    end
  end

endmodule

// File: tb/tb_gray_stream_decoder.sv
// Bench for gray_stream_decoder: directed table, randomized model run, saturation and reset corners.
// Honours GRAY_DIR_DETECT_EN for expected direction codes.
module tb_gray_stream_decoder;

  localparam int W = 4;

`ifdef GRAY_DIR_DETECT_EN
  localparam bit DIR_EN = 1'b1;
`else
  localparam bit DIR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic [W-1:0] in_gray;

  logic         in_ready, out_valid, out_step_err;
  logic [W-1:0] out_binary;
  logic [15:0]  err_count;
  logic [1:0]   out_dir;

  logic         s_in_ready, s_out_valid, s_out_step_err;
  logic [W-1:0] s_out_binary;
  logic [1:0]   s_err_count;
  logic [1:0]   s_out_dir;

  gray_stream_decoder #(.WIDTH(W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_gray(in_gray),
    .out_valid(out_valid), .out_ready(out_ready), .out_binary(out_binary),
    .out_step_err(out_step_err), .err_count(err_count), .out_dir(out_dir)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation.
  gray_stream_decoder #(.WIDTH(W), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_gray(in_gray),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_binary(s_out_binary),
    .out_step_err(s_out_step_err), .err_count(s_err_count), .out_dir(s_out_dir)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of expected output words plus checker state.
  typedef struct packed {
    logic [W-1:0] bin;
    logic         err;
    logic [1:0]   dir;
  } ent_t;

  ent_t         mq[$];
  bit           m_first = 1'b1;
  logic [W-1:0] m_prev_gray = '0;
  logic [W-1:0] m_prev_bin = '0;
  int           m_cnt = 0;
  bit           cur_r, cur_v, cur_o;
  logic [W-1:0] cur_g;

  // Binary value n whose Gray code n^(n>>1) equals g, found by search.
  function automatic logic [W-1:0] ref_decode(input logic [W-1:0] g);
    for (int n = 0; n < 2**W; n++) begin
      if (W'(n ^ (n >> 1)) == g) return W'(n);
    end
    return '0;
  endfunction

  task automatic apply(input bit r, input bit v, input logic [W-1:0] g, input bit o);
    rst = r; in_valid = v; in_gray = g; out_ready = o;
    cur_r = r; cur_v = v; cur_g = g; cur_o = o;
    #1;
  endtask

  task automatic tick();
    bit acc, pop;
    ent_t e;
    logic [W-1:0] diff;
    pop = (mq.size() > 0) && cur_o && !cur_r;
    acc = cur_v && ((mq.size() < 2) || cur_o) && !cur_r;
    e = '0;
    if (acc) begin
      e.bin = ref_decode(cur_g);
      e.err = !m_first && ($countones(cur_g ^ m_prev_gray) != 1);
      diff  = e.bin - m_prev_bin;
      e.dir = 2'b00;
      if (DIR_EN && !m_first) begin
        if (diff == W'(1)) e.dir = 2'b01;
        else if (diff == {W{1'b1}}) e.dir = 2'b10;
      end
    end
    @(posedge clk);
    if (cur_r) begin
      mq.delete();
      m_first = 1'b1; m_prev_gray = '0; m_prev_bin = '0; m_cnt = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (acc) begin
        mq.push_back(e);
        if (e.err) m_cnt++;
        m_first = 1'b0; m_prev_gray = cur_g; m_prev_bin = e.bin;
      end
    end
    @(negedge clk);
  endtask

  task automatic model_check();
    int sat;
    sat = (m_cnt > 3) ? 3 : m_cnt;
    chk("m_out_valid", out_valid, mq.size() > 0);
    chk("m_in_ready", in_ready, (mq.size() < 2) || cur_o);
    chk("m_err_count", err_count, m_cnt);
    chk("m_sat_count", s_err_count, sat);
    chk("m_sat_ready", s_in_ready, (mq.size() < 2) || cur_o);
    if (mq.size() > 0) begin
      chk("m_out_binary", out_binary, mq[0].bin);
      chk("m_out_step_err", out_step_err, mq[0].err);
      chk("m_out_dir", out_dir, mq[0].dir);
      chk("m_sat_binary", s_out_binary, mq[0].bin);
      chk("m_sat_step_err", s_out_step_err, mq[0].err);
      chk("m_sat_dir", s_out_dir, mq[0].dir);
    end
  endtask

  typedef struct {
    bit r; bit v; logic [W-1:0] g; bit o;
    bit e_rdy; bit e_vld; logic [W-1:0] e_bin; bit e_err; logic [1:0] e_dir; int e_cnt;
  } vec_t;

  vec_t tv[22];

  initial begin
    logic [W-1:0] g;
    int sat;

    // Observed values are those present before the clock edge of each row.
    tv[0]  = '{0,1,4'b0000,1, 1,0,4'b0000,0,2'b00,0};
    tv[1]  = '{0,1,4'b0001,1, 1,1,4'b0000,0,2'b00,0};
    tv[2]  = '{0,1,4'b0011,1, 1,1,4'b0001,0,2'b01,0};
    tv[3]  = '{0,1,4'b0010,1, 1,1,4'b0010,0,2'b01,0};
    tv[4]  = '{1,1,4'b1111,1, 1,1,4'b0011,0,2'b01,0};
    tv[5]  = '{0,1,4'b1101,1, 1,0,4'b0000,0,2'b00,0};
    tv[6]  = '{0,1,4'b0111,1, 1,1,4'b1001,0,2'b00,0};
    tv[7]  = '{0,1,4'b0111,1, 1,1,4'b0101,1,2'b00,1};
    tv[8]  = '{0,0,4'b0000,1, 1,1,4'b0101,1,2'b00,2};
    tv[9]  = '{1,0,4'b0000,1, 1,0,4'b0000,0,2'b00,2};
    tv[10] = '{0,1,4'b1100,0, 1,0,4'b0000,0,2'b00,0};
    tv[11] = '{0,1,4'b0100,0, 1,1,4'b1000,0,2'b00,0};
    tv[12] = '{0,1,4'b0101,0, 0,1,4'b1000,0,2'b00,0};
    tv[13] = '{0,1,4'b0101,0, 0,1,4'b1000,0,2'b00,0};
    tv[14] = '{0,1,4'b0101,1, 1,1,4'b1000,0,2'b00,0};
    tv[15] = '{0,0,4'b0000,1, 1,1,4'b0111,0,2'b10,0};
    tv[16] = '{0,0,4'b0000,1, 1,1,4'b0110,0,2'b10,0};
    tv[17] = '{0,1,4'b1000,1, 1,0,4'b0000,0,2'b00,0};
    tv[18] = '{0,1,4'b0000,1, 1,1,4'b1111,1,2'b00,1};
    tv[19] = '{0,1,4'b1000,1, 1,1,4'b0000,0,2'b01,1};
    tv[20] = '{0,0,4'b0000,1, 1,1,4'b1111,0,2'b10,1};
    tv[21] = '{0,0,4'b0000,1, 1,0,4'b0000,0,2'b00,1};

    rst = 1'b1; in_valid = 1'b1; in_gray = 4'b0101; out_ready = 1'b1;
    @(negedge clk);
    apply(1, 1, 4'b0101, 1);
    tick();

    for (int i = 0; i < 22; i++) begin
      apply(tv[i].r, tv[i].v, tv[i].g, tv[i].o);
      chk($sformatf("t%0d_in_ready", i), in_ready, tv[i].e_rdy);
      chk($sformatf("t%0d_out_valid", i), out_valid, tv[i].e_vld);
      chk($sformatf("t%0d_err_count", i), err_count, tv[i].e_cnt);
      if (tv[i].e_vld) begin
        chk($sformatf("t%0d_out_binary", i), out_binary, tv[i].e_bin);
        chk($sformatf("t%0d_out_step_err", i), out_step_err, tv[i].e_err);
        chk($sformatf("t%0d_out_dir", i), out_dir, DIR_EN ? tv[i].e_dir : 2'b00);
      end
      tick();
    end

    // Randomized traffic against the model, mostly legal single-bit steps.
    g = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      int sel;
      sel = $urandom_range(0, 99);
      if (sel < 75)      g = g ^ W'(1 << $urandom_range(0, W-1));
      else if (sel < 85) g = g;
      else               g = W'($urandom_range(0, 2**W-1));
      apply($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 80, g,
            $urandom_range(0, 99) < 70);
      model_check();
      tick();
    end

    // Saturation: one first word then five repeats.
    apply(1, 0, 4'b0000, 1);
    tick();
    for (int i = 0; i < 6; i++) begin
      apply(0, 1, 4'b0000, 1);
      model_check();
      tick();
    end
    apply(0, 0, 4'b0000, 1);
    model_check();
    sat = 3;
    chk("sat_hold", s_err_count, sat);
    tick();

    // Reset with the buffer full discards everything.
    apply(0, 1, 4'b0001, 0);
    tick();
    apply(0, 1, 4'b0011, 0);
    tick();
    apply(1, 1, 4'b0010, 0);
    model_check();
    chk("full_before_rst", in_ready, 1'b0);
    tick();
    apply(0, 1, 4'b1111, 1);
    model_check();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_err_count", err_count, 0);
    chk("rst_out_binary", out_binary, 0);
    chk("rst_out_step_err", out_step_err, 1'b0);
    chk("rst_out_dir", out_dir, 2'b00);
    tick();
    apply(0, 0, 4'b0000, 1);
    model_check();
    chk("post_rst_first_err", out_step_err, 1'b0);
    chk("post_rst_count", err_count, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
